// File: rtl/ps2_pkg.sv
// Shared constants, state types and helpers for the PS/2 keyboard front end.
// Byte values are the set-2 protocol bytes that the prefix logic reacts to.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;
  localparam logic [7:0] PS2_BAT    = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_KERR   = 8'hFF;
  localparam logic [7:0] PS2_OVR    = 8'h00;

  typedef enum logic {
    IDLE,
    RX
  } rx_state_t;

  typedef enum logic [1:0] {
    BASE,
    EXT,
    BRK
  } pfx_state_t;

  // Keyboard housekeeping bytes that never form a key event.
  function automatic logic is_ignored(input logic [7:0] b);
    return (b == PS2_PAUSE)  || (b == PS2_BAT)  ||
           (b == PS2_ACK)    || (b == PS2_ECHO) ||
           (b == PS2_RESEND) || (b == PS2_KERR) ||
           (b == PS2_OVR);
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: sync, edge detect, shift, checks.
// Emits a one-cycle byte strobe or error strobe per completed frame.
module ps2_frame_rx #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err
);
  import ps2_pkg::*;

  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LIM = WDW'(TIMEOUT_CYCLES - 1);

  logic [1:0]     clk_sync_q;
  logic [1:0]     dat_sync_q;
  logic           clk_prev_q;
  rx_state_t      state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [7:0]     sh_q, sh_d;
  logic           par_q, par_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic           valid_q, valid_d;
  logic           err_q, err_d;

  logic fall;
  logic din;
  logic timeout;
  logic frame_ok;

  assign fall     = clk_prev_q & ~clk_sync_q[1];
  assign din      = dat_sync_q[1];
  assign timeout  = (wd_q == WD_LIM);
  assign frame_ok = (^{sh_q, par_q}) & din;

  // Two-flop synchronisers plus previous-clock flop; idle-high on reset.
  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_data};
      clk_prev_q <= clk_sync_q[1];
    end
  end

  // Receiver state, bit counter, shift register and watchdog.
  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      sh_q    <= 8'd0;
      par_q   <= 1'b0;
      wd_q    <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      wd_q    <= wd_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Next-state: start detect, data/parity capture, stop check, timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    par_d   = par_q;
    wd_d    = wd_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        wd_d  = '0;
        cnt_d = 4'd0;
        if (fall && !din) begin
          state_d = RX;
          cnt_d   = 4'd1;
        end
      end
      RX: begin
        if (fall) begin
          wd_d  = '0;
          cnt_d = cnt_q + 4'd1;
          unique case (1'b1)
            (cnt_q <= 4'd8): sh_d  = {din, sh_q[7:1]};
            (cnt_q == 4'd9): par_d = din;
            default: begin
              state_d = IDLE;
              cnt_d   = 4'd0;
              valid_d = frame_ok;
              err_d   = ~frame_ok;
            end
          endcase
        end else if (timeout) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
          wd_d    = '0;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_byte  = sh_q;
  assign rx_valid = valid_q;
  assign rx_err   = err_q;

endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 scan decoder top: frame receiver plus E0/F0 prefix folding.
// Produces a 9-bit key code with one-cycle make/break/error pulses.
module ps2_scan_decoder #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [8:0] keyCode,
  output logic       make,
  output logic       brakee,
  output logic       frame_err
);
  import ps2_pkg::*;

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk     (clk),
    .resetN  (resetN),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .rx_byte (rx_byte),
    .rx_valid(rx_valid),
    .rx_err  (rx_err)
  );

  pfx_state_t pfx_q, pfx_d;
  logic       ext_q, ext_d;
  logic [8:0] key_q, key_d;
  logic       make_q, make_d;
  logic       brk_q, brk_d;
  logic       ferr_q, ferr_d;

  logic b_ext;
  logic b_brk;
  logic b_ign;

  assign b_ext = (rx_byte == PS2_EXT);
  assign b_brk = (rx_byte == PS2_BRK);
  assign b_ign = is_ignored(rx_byte);

  // Prefix state and registered outputs.
  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      pfx_q  <= BASE;
      ext_q  <= 1'b0;
      key_q  <= 9'd0;
      make_q <= 1'b0;
      brk_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      pfx_q  <= pfx_d;
      ext_q  <= ext_d;
      key_q  <= key_d;
      make_q <= make_d;
      brk_q  <= brk_d;
      ferr_q <= ferr_d;
    end
  end

  // Fold prefix bytes; emit key events; errors drop any pending prefix.
  always_comb begin
    pfx_d  = pfx_q;
    ext_d  = ext_q;
    key_d  = key_q;
    make_d = 1'b0;
    brk_d  = 1'b0;
    ferr_d = 1'b0;
    if (rx_err) begin
      ferr_d = 1'b1;
      ext_d  = 1'b0;
      pfx_d  = BASE;
    end else if (rx_valid) begin
      unique case (1'b1)
        b_ext: begin
          ext_d = 1'b1;
          pfx_d = EXT;
        end
        b_brk: pfx_d = BRK;
        b_ign: begin
          ext_d = 1'b0;
          pfx_d = BASE;
        end
        default: begin
          key_d  = {ext_q, rx_byte};
          make_d = (pfx_q != BRK);
          brk_d  = (pfx_q == BRK);
          ext_d  = 1'b0;
          pfx_d  = BASE;
        end
      endcase
    end
  end

  assign keyCode   = key_q;
  assign make      = make_q;
  assign brakee    = brk_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Directed bench for ps2_scan_decoder: drives PS/2 frames and checks
// decoded key codes, pulse counts, latency, errors and reset behaviour.
module tb_ps2_scan_decoder;

  localparam int TO = 300;
  localparam int H  = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pc  = 1'b1;
  logic       pd  = 1'b1;
  logic [8:0] keyCode;
  logic       make;
  logic       brakee;
  logic       frame_err;

  ps2_scan_decoder #(
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk      (clk),
    .resetN   (rst),
    .ps2_clk  (pc),
    .ps2_data (pd),
    .keyCode  (keyCode),
    .make     (make),
    .brakee   (brakee),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int mk_n = 0, bk_n = 0, fe_n = 0, both_n = 0, mk_cyc = 0;
  logic [8:0] mk_key = '0, bk_key = '0;
  always @(negedge clk) begin
    if (make) begin
      mk_n   <= mk_n + 1;
      mk_key <= keyCode;
      mk_cyc <= cyc;
    end
    if (brakee) begin
      bk_n   <= bk_n + 1;
      bk_key <= keyCode;
    end
    if (frame_err) fe_n <= fe_n + 1;
    if (make && brakee) both_n <= both_n + 1;
  end

  int total = 0, passed = 0;
  int m0, b0, e0, stop_cyc;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic snap();
    @(negedge clk);
    m0 = mk_n;
    b0 = bk_n;
    e0 = fe_n;
  endtask

  task automatic ps2_bit(input logic b);
    repeat (H) @(negedge clk);
    pd = b;
    repeat (H) @(negedge clk);
    pc = 1'b0;
    stop_cyc = cyc;
    repeat (H) @(negedge clk);
    pc = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input bit bad, input int nb);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad, b, 1'b0};
    for (int i = 0; i < nb; i++) ps2_bit(f[i]);
    repeat (2 * H) @(negedge clk);
  endtask

  initial begin
    repeat (5) @(negedge clk);
    chk("rst_key", int'(keyCode), 0);
    chk("rst_make", int'(make), 0);
    chk("rst_brk", int'(brakee), 0);
    chk("rst_ferr", int'(frame_err), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    snap();
    send(8'h29, 0, 11);
    chk("m29_make", mk_n - m0, 1);
    chk("m29_brk", bk_n - b0, 0);
    chk("m29_ferr", fe_n - e0, 0);
    chk("m29_key", int'(mk_key), 'h029);
    chk("m29_out", int'(keyCode), 'h029);
    chk("m29_lat", mk_cyc - stop_cyc, 4);

    snap();
    send(8'hF0, 0, 11);
    send(8'h29, 0, 11);
    chk("b29_brk", bk_n - b0, 1);
    chk("b29_make", mk_n - m0, 0);
    chk("b29_key", int'(bk_key), 'h029);

    snap();
    send(8'hE0, 0, 11);
    send(8'h75, 0, 11);
    chk("m175_make", mk_n - m0, 1);
    chk("m175_key", int'(mk_key), 'h175);
    snap();
    send(8'hE0, 0, 11);
    send(8'hF0, 0, 11);
    send(8'h75, 0, 11);
    chk("b175_brk", bk_n - b0, 1);
    chk("b175_make", mk_n - m0, 0);
    chk("b175_key", int'(bk_key), 'h175);

    snap();
    send(8'h29, 1, 11);
    chk("par_ferr", fe_n - e0, 1);
    chk("par_make", mk_n - m0, 0);
    send(8'h1C, 0, 11);
    chk("par_1c_make", mk_n - m0, 1);
    chk("par_1c_key", int'(mk_key), 'h01C);

    snap();
    send(8'hE0, 0, 11);
    send(8'h33, 1, 11);
    send(8'h1C, 0, 11);
    chk("errext_ferr", fe_n - e0, 1);
    chk("errext_key", int'(mk_key), 'h01C);

    snap();
    send(8'hE0, 0, 11);
    send(8'hAA, 0, 11);
    send(8'h1C, 0, 11);
    chk("ign_make", mk_n - m0, 1);
    chk("ign_key", int'(mk_key), 'h01C);

    snap();
    send(8'h29, 0, 11);
    send(8'h29, 0, 11);
    chk("typ_make", mk_n - m0, 2);

    snap();
    send(8'h12, 0, 5);
    repeat (TO + 50) @(negedge clk);
    chk("to_ferr", fe_n - e0, 1);
    chk("to_make", mk_n - m0, 0);
    send(8'hE0, 0, 11);
    send(8'h6B, 0, 11);
    chk("to_16b_make", mk_n - m0, 1);
    chk("to_16b_key", int'(mk_key), 'h16B);

    send(8'hE0, 0, 11);
    send(8'h29, 0, 6);
    repeat (H) @(negedge clk);
    pd = 1'b0;
    repeat (H) @(negedge clk);
    pc = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_key", int'(keyCode), 0);
    chk("mid_make", int'(make), 0);
    chk("mid_brk", int'(brakee), 0);
    chk("mid_ferr", int'(frame_err), 0);
    pc = 1'b1;
    pd = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    repeat (2 * H) @(negedge clk);
    snap();
    send(8'h29, 0, 11);
    chk("post_make", mk_n - m0, 1);
    chk("post_ferr", fe_n - e0, 0);
    chk("post_key", int'(keyCode), 'h029);
    chk("post_ext", int'(keyCode[8]), 0);

    chk("never_both", both_n, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ps2_scan_decoder.md
# ps2_scan_decoder

Front end of the keyboard path. Receives raw PS/2 clock/data lines, deserialises 11-bit device-to-host frames and checks start, parity and stop. Folds the E0/F0 prefix bytes into one 9-bit key code with single-cycle make/break pulses. Its outputs `keyCode`, `make` and `brakee` feed every per-key toggle/press decoder directly.

## Interface
- `TIMEOUT_CYCLES`, default 50000: max clk cycles between PS/2 clock falls inside a frame before the frame is aborted (1 ms at 50 MHz).
- `clk`  in  1  system clock, all logic on rising edge.
- `resetN`  in  1  asynchronous, active-high reset (asserted = 1).
- `ps2_clk`  in  1  raw PS/2 clock pin, asynchronous to `clk`.
- `ps2_data`  in  1  raw PS/2 data pin, asynchronous to `clk`.
- `keyCode`  out  9  last decoded key; bit 8 = E0-extended, bits 7:0 = scan code; held until next decoded key.
- `make`  out  1  one-cycle pulse, key pressed, valid with `keyCode` in the same cycle.
- `brakee`  out  1  one-cycle pulse, key released, valid with `keyCode` in the same cycle.
- `frame_err`  out  1  one-cycle pulse, a frame was discarded (bad start/parity/stop or timeout).

## Operation
- Input conditioning: `ps2_clk` and `ps2_data` each pass through a 2-FF synchroniser. Falling edge = previous synced clk 1, current 0.
- Frame receiver FSM: IDLE, RX.
  - IDLE → RX on a falling edge with synced data = 0 (start bit). A falling edge with data = 1 in IDLE is ignored.
  - RX: bit counter 1..10. Bits 1-8 are data, LSB first. Bit 9 is parity: the XOR of the 8 data bits and the parity bit must be 1 (odd). Bit 10 is stop and must be 1.
  - Frame complete at bit 10: valid → internal byte strobe. Invalid → `frame_err` and the byte is dropped. Either way → IDLE.
  - Watchdog: reset on every falling edge and in IDLE. In RX, reaching `TIMEOUT_CYCLES-1` → `frame_err`, IDLE, partial byte discarded.
- Prefix FSM: BASE, EXT (E0 seen), BRK (F0 seen). Separate ext flag is set by E0 and survives into BRK.
  - E0 → ext=1, state EXT. F0 → state BRK (from BASE or EXT).
  - Any other byte emits `keyCode={ext,byte}`, with `make` in BASE/EXT or `brakee` in BRK, then clears ext → BASE.
  - Bytes E1, AA, FA, EE, FE, FF, 00 emit nothing and clear ext → BASE.
  - `frame_err` also clears ext → BASE, so no later byte is mis-tagged.
- `make` and `brakee` are never high together. Repeated makes (typematic) are emitted as separate pulses.

## Timing
- Reset values: `keyCode`=0, `make`=0, `brakee`=0, `frame_err`=0. Both FSMs idle, counters 0, synchronisers 1 (PS/2 idle-high).
- Latency: `make`/`brakee`/`keyCode` update exactly 3 clk cycles after the first clk edge at which synchroniser stage 1 captures `ps2_clk` low for the stop bit. `frame_err` has the same latency for parity/stop errors. For a timeout, `frame_err` asserts the cycle after the watchdog hits its limit.
- No back-pressure. The consumer must sample the pulses on the cycle they are high.
- Reset mid-frame: partial frame and pending prefix lost. No pulse is generated for it.
- A second frame start immediately after a stop bit is accepted; there is no dead time.

## Structure
- Package `ps2_pkg` holds:
  - byte constants `PS2_EXT=8'hE0`, `PS2_BRK=8'hF0`, `PS2_PAUSE=8'hE1`, and the ignore list;
  - enums `rx_state_t` {IDLE, RX} and `pfx_state_t` {BASE, EXT, BRK}.
- Sub-module `ps2_frame_rx`: synchronisers, edge detect, shift register, parity/stop check, watchdog. Outputs `rx_byte[7:0]`, `rx_valid`, `rx_err`.
- The top level holds the prefix FSM and output registers.

## Test plan
- Frame 0x29 (parity 0) at 12 kHz → `keyCode`=0x029, `make` high 1 cycle, `brakee` 0.
- Frames F0, 29 → single `brakee` pulse, `keyCode`=0x029, no `make`.
- Frames E0, 75 then E0, F0, 75 → `make` with 0x175, then `brakee` with 0x175.
- Frame 0x29 with parity flipped, then good frame 0x1C:
  - first frame → `frame_err` pulse, no `make`;
  - second frame → `make` with `keyCode`=0x01C.
- Stall after 5 bits for longer than `TIMEOUT_CYCLES` → `frame_err` once. A following E0, 6B still decodes to 0x16B.
- Assert `resetN` during bit 6 of frame after E0 → all outputs 0. Next frame 0x29 → `keyCode`=0x029, bit 8 clear.
